// File: rtl/gmii_pkg.sv
// Shared GMII transmit constants and framer state encoding; the CRC stage reuses
// the preamble/SFD bytes from here.
package gmii_pkg;

    localparam logic [7:0] GMII_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] GMII_SFD_BYTE      = 8'hD5;
    localparam logic [7:0] GMII_PAD_BYTE      = 8'h00;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_SFD  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_PAD  = 3'd4;
    localparam logic [2:0] ST_DROP = 3'd5;
    localparam logic [2:0] ST_IFG  = 3'd6;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        PRE  = ST_PRE,
        SFD  = ST_SFD,
        DATA = ST_DATA,
        PAD  = ST_PAD,
        DROP = ST_DROP,
        IFG  = ST_IFG
    } gmii_state_e;

    localparam int BYTE_CNT_W = 11;

    // Frame byte counter stops at all-ones instead of wrapping.
    function automatic logic [BYTE_CNT_W-1:0] sat_inc(input logic [BYTE_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/gmii_tx_framer.sv
// GMII TX framer: preamble/SFD insertion, zero-pad to minimum length, FCS+IPG idle gap.
// Define GMII_TX_MAXLEN_CHECK_EN to abort frames that reach MAX_FRAME bytes.
module gmii_tx_framer
    import gmii_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int MAX_FRAME    = 1514,
    parameter int IFG_CYCLES   = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  frame_data_i,
    input  logic        frame_valid_i,
    input  logic        frame_last_i,
    output logic        frame_ready_o,
    output logic        gmii_dv_o,
    output logic        gmii_er_o,
    output logic [7:0]  gmii_data_o,
    output logic        busy_o,
    output logic [15:0] frame_cnt_o
);

    localparam logic [7:0]            PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0]            IFG_LAST = 8'(IFG_CYCLES - 1);
    localparam logic [BYTE_CNT_W-1:0] MIN_LEN  = BYTE_CNT_W'(MIN_FRAME);
    localparam logic [BYTE_CNT_W-1:0] MAX_LEN  = BYTE_CNT_W'(MAX_FRAME);

`ifdef GMII_TX_MAXLEN_CHECK_EN
    localparam bit LEN_CHECK_EN = 1'b1;
`else
    localparam bit LEN_CHECK_EN = 1'b0;
`endif

    gmii_state_e            r_state;
    logic [7:0]             r_pre_cnt;
    logic [7:0]             r_ifg_cnt;
    logic [BYTE_CNT_W-1:0]  r_byte_cnt;
    logic                   r_len_err;
    logic                   r_dv;
    logic                   r_er;
    logic [7:0]             r_data;
    logic [15:0]            r_frame_cnt;

    logic [BYTE_CNT_W-1:0]  w_byte_cnt_inc;
    logic                   w_at_max_len;

    assign w_byte_cnt_inc = sat_inc(r_byte_cnt);
    assign w_at_max_len   = LEN_CHECK_EN && (w_byte_cnt_inc == MAX_LEN);

    assign frame_ready_o = (r_state == DATA) || (r_state == DROP);
    assign busy_o        = (r_state != IDLE);
    assign gmii_dv_o     = r_dv;
    assign gmii_er_o     = r_er;
    assign gmii_data_o   = r_data;
    assign frame_cnt_o   = r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pre_cnt   <= '0;
            r_ifg_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_len_err   <= 1'b0;
            r_dv        <= 1'b0;
            r_er        <= 1'b0;
            r_data      <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_dv   <= 1'b0;
            r_er   <= 1'b0;
            r_data <= GMII_PAD_BYTE;
            case (r_state)
                IDLE: begin
                    if (frame_valid_i) begin
                        r_state   <= PRE;
                        r_pre_cnt <= '0;
                    end
                end
                PRE: begin
                    r_dv   <= 1'b1;
                    r_data <= GMII_PREAMBLE_BYTE;
                    if (r_pre_cnt == PRE_LAST) begin
                        r_state <= SFD;
                    end else begin
                        r_pre_cnt <= r_pre_cnt + 8'd1;
                    end
                end
                SFD: begin
                    r_dv       <= 1'b1;
                    r_data     <= GMII_SFD_BYTE;
                    r_state    <= DATA;
                    r_byte_cnt <= '0;
                end
                DATA: begin
                    r_dv <= 1'b1;
                    if (frame_valid_i) begin
                        r_data     <= frame_data_i;
                        r_byte_cnt <= w_byte_cnt_inc;
                        if (frame_last_i) begin
                            if (w_byte_cnt_inc < MIN_LEN) begin
                                r_state <= PAD;
                            end else begin
                                r_state     <= IFG;
                                r_ifg_cnt   <= '0;
                                r_frame_cnt <= r_frame_cnt + 16'd1;
                            end
                        end else if (w_at_max_len) begin
                            // Oversize byte goes out intact; the error cycle follows from DROP.
                            r_state   <= DROP;
                            r_len_err <= 1'b1;
                        end
                    end else begin
                        r_er    <= 1'b1;
                        r_state <= DROP;
                    end
                end
                PAD: begin
                    r_dv       <= 1'b1;
                    r_byte_cnt <= w_byte_cnt_inc;
                    if (w_byte_cnt_inc == MIN_LEN) begin
                        r_state     <= IFG;
                        r_ifg_cnt   <= '0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                DROP: begin
                    if (r_len_err) begin
                        r_dv      <= 1'b1;
                        r_er      <= 1'b1;
                        r_len_err <= 1'b0;
                    end
                    if (frame_valid_i && frame_last_i) begin
                        r_state   <= IFG;
                        r_ifg_cnt <= '0;
                    end
                end
                IFG: begin
                    if (r_ifg_cnt == IFG_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_ifg_cnt <= r_ifg_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Randomized bench for gmii_tx_framer: a per-edge expected GMII trace is planned per frame
// from the framing rules and compared every cycle, plus literal run-length/count checks.
module tb_gmii_tx_framer;

    localparam int MAXC = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  frame_data_i = 8'h00;
    logic        frame_valid_i = 1'b0;
    logic        frame_last_i = 1'b0;
    logic        frame_ready_o;
    logic        gmii_dv_o;
    logic        gmii_er_o;
    logic [7:0]  gmii_data_o;
    logic        busy_o;
    logic [15:0] frame_cnt_o;

    gmii_tx_framer dut (
        .clk           (clk),
        .rst           (rst),
        .frame_data_i  (frame_data_i),
        .frame_valid_i (frame_valid_i),
        .frame_last_i  (frame_last_i),
        .frame_ready_o (frame_ready_o),
        .gmii_dv_o     (gmii_dv_o),
        .gmii_er_o     (gmii_er_o),
        .gmii_data_o   (gmii_data_o),
        .busy_o        (busy_o),
        .frame_cnt_o   (frame_cnt_o)
    );

    always #4 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int total = 0;
    int bad   = 0;

    // exp_out[k]: {dv,er,data} registered at edge k. exp_rdy/exp_busy[k]: level during the cycle ending at edge k.
    logic [9:0] exp_out  [MAXC];
    bit         exp_rdy  [MAXC];
    bit         exp_busy [MAXC];
    logic [1:0] cnt_evt  [MAXC];
    logic [15:0] mcnt = 16'd0;
    bit          chk_en = 1'b0;
    int          next_idle = 0;
    logic [7:0]  fbuf [2048];

    int run = 0, low = 0, last_run = 0, last_gap = 0, er_pulses = 0;

    task automatic summary();
        $display("test done: total=%0d bad=%0d", total, bad);
    endtask

    task automatic abort_run(input string what);
        total++;
        bad++;
        $display("FAIL %s: bound expired before DUT responded", what);
        summary();
        $fatal(1, "aborted");
    endtask

    task automatic check_lit(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic void put(input int c, input logic [9:0] v);
        if (c < MAXC) exp_out[c] = v;
    endfunction

    // Frame observed by the framer's IDLE state at edge e0; u>=0 means valid drops for g cycles after u bytes.
    function automatic void plan(input int e0, input int n, input int u, input int g);
        int  base, e_end, last_take;
        bit  good, maxl;
        base = e0 + 9;
        maxl = 1'b0;
`ifdef GMII_TX_MAXLEN_CHECK_EN
        maxl = (n > 1514);
`endif
        for (int i = 0; i < 7; i++) put(e0 + 1 + i, {2'b10, 8'h55});
        put(e0 + 8, {2'b10, 8'hD5});
        if (u >= 0) begin
            for (int i = 0; i < u; i++) put(base + i, {2'b10, fbuf[i]});
            put(base + u, {2'b11, 8'h00});
            e_end = e0 + 8 + n + g;
            good  = 1'b0;
        end else if (maxl) begin
            for (int i = 0; i < 1514; i++) put(base + i, {2'b10, fbuf[i]});
            put(base + 1514, {2'b11, 8'h00});
            e_end = e0 + 8 + n;
            good  = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) put(base + i, {2'b10, fbuf[i]});
            for (int i = n; i < 60; i++) put(base + i, {2'b10, 8'h00});
            e_end = e0 + 8 + ((n > 60) ? n : 60);
            good  = 1'b1;
        end
        last_take = e0 + 8 + n + ((u >= 0) ? g : 0);
        for (int k = e0 + 9; k <= last_take && k < MAXC; k++) exp_rdy[k] = 1'b1;
        for (int k = e0 + 1; k <= e_end + 17 && k < MAXC; k++) exp_busy[k] = 1'b1;
        if (good && e_end < MAXC) cnt_evt[e_end] = 2'd1;
        next_idle = e_end + 18;
    endfunction

    function automatic void reset_at(input int r);
        for (int c = r; c < MAXC; c++) exp_out[c] = 10'd0;
        for (int c = r + 1; c < MAXC; c++) begin
            exp_rdy[c]  = 1'b0;
            exp_busy[c] = 1'b0;
            cnt_evt[c]  = 2'd0;
        end
        cnt_evt[r] = 2'd2;
    endfunction

    // Per-cycle scoreboard compare.
    always @(negedge clk) begin
        if (chk_en && edge_n + 1 < MAXC) begin
            if (cnt_evt[edge_n] == 2'd1) mcnt = mcnt + 16'd1;
            else if (cnt_evt[edge_n] == 2'd2) mcnt = 16'd0;
            total++;
            if ({gmii_dv_o, gmii_er_o, gmii_data_o} !== exp_out[edge_n]) begin
                bad++;
                $display("FAIL gmii_out edge=%0d got dv=%0b er=%0b data=%02h want dv=%0b er=%0b data=%02h",
                         edge_n, gmii_dv_o, gmii_er_o, gmii_data_o,
                         exp_out[edge_n][9], exp_out[edge_n][8], exp_out[edge_n][7:0]);
            end
            total++;
            if (frame_ready_o !== exp_rdy[edge_n + 1] || busy_o !== exp_busy[edge_n + 1]) begin
                bad++;
                $display("FAIL ready_busy edge=%0d got ready=%0b busy=%0b want ready=%0b busy=%0b",
                         edge_n, frame_ready_o, busy_o, exp_rdy[edge_n + 1], exp_busy[edge_n + 1]);
            end
            total++;
            if (frame_cnt_o !== mcnt) begin
                bad++;
                $display("FAIL frame_cnt edge=%0d got %0d want %0d", edge_n, frame_cnt_o, mcnt);
            end
        end
    end

    always @(negedge clk) begin
        if (gmii_er_o) er_pulses++;
        if (gmii_dv_o) begin
            if (low > 0) begin
                last_gap = low;
                low = 0;
            end
            run++;
        end else begin
            if (run > 0) begin
                last_run = run;
                run = 0;
            end
            low++;
        end
    end

    task automatic send_frame(input int n, input int u, input int g, input int rst_at);
        int e0, i, w;
        @(negedge clk);
        frame_data_i  = fbuf[0];
        frame_valid_i = 1'b1;
        frame_last_i  = (n == 1);
        e0 = (edge_n + 1 > next_idle) ? edge_n + 1 : next_idle;
        plan(e0, n, u, g);
        i = 0;
        while (i < n) begin
            w = 0;
            while (!frame_ready_o) begin
                @(negedge clk);
                w++;
                if (w > 3000) abort_run("ready_wait");
            end
            @(posedge clk);
            i++;
            if (i == rst_at) begin
                @(negedge clk);
                frame_valid_i = 1'b0;
                frame_last_i  = 1'b0;
                rst = 1'b1;
                reset_at(edge_n + 1);
                @(negedge clk);
                rst = 1'b0;
                next_idle = edge_n + 1;
                check_lit("rst_dv", int'(gmii_dv_o), 0);
                check_lit("rst_er", int'(gmii_er_o), 0);
                check_lit("rst_data", int'(gmii_data_o), 0);
                check_lit("rst_busy", int'(busy_o), 0);
                check_lit("rst_cnt", int'(frame_cnt_o), 0);
                return;
            end
            if (i == u) begin
                repeat (g) begin
                    @(negedge clk);
                    frame_valid_i = 1'b0;
                    frame_last_i  = 1'b0;
                    @(posedge clk);
                end
            end
            if (i < n) begin
                @(negedge clk);
                frame_data_i  = fbuf[i];
                frame_valid_i = 1'b1;
                frame_last_i  = (i == n - 1);
            end
        end
        @(negedge clk);
        frame_valid_i = 1'b0;
        frame_last_i  = 1'b0;
    endtask

    task automatic wait_idle();
        while (edge_n < next_idle + 1) @(negedge clk);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) fbuf[i] = 8'($urandom);
    endtask

    initial begin
        #(8 * 60000);
        total++;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int n, u, g, gap, er0;
        for (int c = 0; c < MAXC; c++) begin
            exp_out[c]  = 10'd0;
            exp_rdy[c]  = 1'b0;
            exp_busy[c] = 1'b0;
            cnt_evt[c]  = 2'd0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        next_idle = edge_n + 1;
        chk_en = 1'b1;
        check_lit("reset_dv", int'(gmii_dv_o), 0);
        check_lit("reset_er", int'(gmii_er_o), 0);
        check_lit("reset_data", int'(gmii_data_o), 0);
        check_lit("reset_busy", int'(busy_o), 0);
        check_lit("reset_ready", int'(frame_ready_o), 0);
        check_lit("reset_cnt", int'(frame_cnt_o), 0);

        // 64-byte incrementing frame
        for (int i = 0; i < 64; i++) fbuf[i] = 8'(i);
        send_frame(64, -1, 0, -1);
        wait_idle();
        check_lit("f64_dv_run", last_run, 72);
        check_lit("f64_cnt", int'(frame_cnt_o), 1);
        $display("frame 64B done run=%0d", last_run);

        // 10-byte frame padded to 60
        for (int i = 0; i < 10; i++) fbuf[i] = 8'(8'hA0 + i);
        send_frame(10, -1, 0, -1);
        wait_idle();
        check_lit("f10_dv_run", last_run, 68);
        check_lit("f10_cnt", int'(frame_cnt_o), 2);
        $display("frame 10B done run=%0d", last_run);

        // back-to-back: second frame requested during the first one's IFG
        fill_rand(20);
        send_frame(20, -1, 0, -1);
        fill_rand(30);
        send_frame(30, -1, 0, -1);
        wait_idle();
        check_lit("b2b_gap", last_gap, 18);
        check_lit("b2b_run", last_run, 68);
        check_lit("b2b_cnt", int'(frame_cnt_o), 4);
        $display("back-to-back done gap=%0d", last_gap);

        // underrun after byte 20 of 100
        er0 = er_pulses;
        fill_rand(100);
        send_frame(100, 20, 3, -1);
        wait_idle();
        check_lit("underrun_er", er_pulses, er0 + 1);
        check_lit("underrun_run", last_run, 29);
        check_lit("underrun_cnt", int'(frame_cnt_o), 4);
        $display("underrun frame done er_pulses=%0d", er_pulses);

        // reset at payload byte 30, then a fresh frame
        fill_rand(100);
        send_frame(100, -1, 0, 30);
        fill_rand(40);
        send_frame(40, -1, 0, -1);
        wait_idle();
        check_lit("post_rst_cnt", int'(frame_cnt_o), 1);
        check_lit("post_rst_run", last_run, 68);
        $display("reset-recovery frame done cnt=%0d", frame_cnt_o);

        // randomized frames around the padding boundary, with underruns and idle spacing
        for (int t = 0; t < 24; t++) begin
            case ($urandom_range(0, 3))
                0: n = 59 + int'($urandom_range(0, 2));
                1: n = int'($urandom_range(1, 3));
                default: n = int'($urandom_range(1, 130));
            endcase
            u = -1;
            g = 0;
            if (n >= 2 && $urandom_range(0, 3) == 0) begin
                u = int'($urandom_range(1, n - 1));
                g = int'($urandom_range(1, 4));
            end
            gap = int'($urandom_range(0, 25));
            fill_rand(n);
            repeat (gap) @(negedge clk);
            send_frame(n, u, g, -1);
            $display("random frame %0d len=%0d underrun_at=%0d", t, n, u);
        end
        wait_idle();

        // oversize frame
        fill_rand(1600);
        send_frame(1600, -1, 0, -1);
        wait_idle();
`ifdef GMII_TX_MAXLEN_CHECK_EN
        check_lit("f1600_run", last_run, 1523);
`else
        check_lit("f1600_run", last_run, 1608);
`endif
        $display("frame 1600B done run=%0d", last_run);

        summary();
        $finish;
    end

endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
- Upstream neighbour of the GMII CRC appender on the transmit path.
- Takes a byte-stream Ethernet frame (DA..payload, no FCS) from the TX buffer over a valid/ready/last interface.
- Emits GMII with 7x 0x55 preamble, 0xD5 SFD, payload, and zero-padding to the 60-byte minimum.
- Enforces an idle gap long enough for the downstream stage to append the 4-byte FCS and still leave the 12-byte IPG.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes before SFD
- MIN_FRAME, 60, minimum bytes DA..payload before FCS; shorter frames are padded with 0x00
- MAX_FRAME, 1514, maximum bytes DA..payload (used only with the optional feature)
- IFG_CYCLES, 17, dv-low cycles after the last data/pad byte: 4 FCS + 1 CRC-stage return + 12 IPG

Ports:
- clk  in  1  GMII TX clock, 125 MHz
- rst  in  1  synchronous active-high reset
- frame_data_i  in  8  frame byte
- frame_valid_i  in  1  frame_data_i valid
- frame_last_i  in  1  final byte of frame; qualified by valid
- frame_ready_o  out  1  byte accepted when valid&ready
- gmii_dv_o  out  1  to CRC stage gmii_dv_i
- gmii_er_o  out  1  to CRC stage gmii_er_i
- gmii_data_o  out  8  to CRC stage gmii_data_i
- busy_o  out  1  state != IDLE
- frame_cnt_o  out  16  frames completed (PAD/DATA->IFG), wraps 0xFFFF->0

Behaviour:
- Interface decisions: one clock, clk; reset rst is synchronous and active-high. All GMII outputs are registered.
- Reset (incl. mid-frame): next edge forces IDLE. gmii_dv_o=0, gmii_er_o=0, gmii_data_o=0, frame_ready_o=0, frame_cnt_o=0, counters=0. A partially sent frame is truncated with no error marking.
- frame_ready_o is combinational: 1 only in DATA and DROP.
- FSM (next state and registered output of the transition cycle):
  - IDLE: frame_valid_i=1 -> PRE, pre_cnt=0. dv=0.
  - PRE: emit dv=1, data=0x55. After PREAMBLE_LEN cycles -> SFD.
  - SFD: emit dv=1, data=0xD5 for one cycle -> DATA, byte_cnt=0.
  - DATA, valid=1: emit dv=1, data=frame_data_i; byte_cnt+1 (11 bits, saturating at 2047).
    - If last and byte_cnt+1 < MIN_FRAME -> PAD.
    - If last otherwise -> IFG, ifg_cnt=0.
  - DATA, valid=0 (underrun): emit dv=1, er=1, data=0x00 for one cycle -> DROP.
  - PAD: emit dv=1, data=0x00; byte_cnt+1. When byte_cnt+1 == MIN_FRAME -> IFG.
  - DROP: dv=0, er=0; discard bytes until valid&last -> IFG.
    - A frame in DROP does not increment frame_cnt_o.
  - IFG: dv=0, er=0, data=0 for IFG_CYCLES cycles -> IDLE. frame_valid_i is ignored during IFG.
- Latency: first 0x55 appears 1 cycle after IDLE sees valid. The first payload byte appears PREAMBLE_LEN+1 cycles after that.
- dv is continuous from first 0x55 to last data/pad byte, so there is exactly one dv rising edge per frame (the CRC stage relies on this).
- A 1-byte frame (valid&last on the first DATA cycle) pads 59 bytes.
- A frame of exactly MIN_FRAME bytes gets no PAD.
- A 0-length frame is impossible: DATA is only entered after IDLE saw valid.

Optional Feature:
- Macro: GMII_TX_MAXLEN_CHECK_EN.
- Defined: in DATA, if an accepted non-last byte makes byte_cnt+1 == MAX_FRAME:
  - the next emitted cycle is dv=1, er=1, data=0x00, then DROP;
  - frame_cnt_o is not incremented for that frame.
- Undefined: no length limit; byte_cnt saturates at 2047 and the frame passes unchanged.

Decomposition:
- Shared package gmii_pkg holds:
  - constants GMII_PREAMBLE_BYTE=8'h55, GMII_SFD_BYTE=8'hD5, GMII_PAD_BYTE=8'h00;
  - state encoding localparams IDLE/PRE/SFD/DATA/PAD/DROP/IFG (3-bit).
- The CRC stage shares the preamble/SFD constants.
- No sub-module: the single FSM with three counters is self-contained.

Test Plan:
- 64-byte frame 0x00..0x3F, valid held high, last on 0x3F.
  - Expect 7x0x55, 0xD5, then 64 bytes unchanged, dv high for 72 consecutive cycles, then dv low 17 cycles.
  - frame_cnt_o=1.
- 10-byte frame 0xA0..0xA9.
  - Expect 10 bytes then 50x0x00; dv high 68 cycles total; ready low during PAD.
- Back-to-back: second frame valid during IFG.
  - Expect no ready until IFG ends; second preamble starts exactly 18 cycles after first dv fall (17 IFG + 1 IDLE).
- Underrun: valid drops after payload byte 20 of 100.
  - Expect one cycle dv=1 er=1 data=0; dv low thereafter.
  - Remaining bytes consumed with ready=1 until last; frame_cnt_o unchanged.
- rst asserted at payload byte 30.
  - Next edge: dv=0, er=0, data=0, busy_o=0, frame_cnt_o=0.
  - A new frame afterwards is framed correctly from the preamble.
- GMII_TX_MAXLEN_CHECK_EN defined, 1600-byte frame.
  - Expect er pulse after byte 1514, dv low, DROP to last, count unchanged.
  - With the macro undefined, all 1600 bytes pass.
